// File: rtl/train_pkg.sv
// Shared types and defaults for the siding dispatch controller and its stack.
// Holds the sequencer state encoding and the PUSH/POP command encodings.
package train_pkg;

    localparam int MAX_CARS_DEF = 10;
    localparam int ID_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/train_dispatch_ctrl_if.sv
// Input beat stream, command stream and completion status of the dispatch controller.
// The master drives beats and cmd_ready; the slave is the controller.
interface train_dispatch_ctrl_if #(
    parameter int ID_W = 4
);
    logic            in_valid;
    logic [ID_W-1:0] data;
    logic            cmd_ready;
    logic            cmd_valid;
    logic            cmd_op;
    logic [ID_W-1:0] cmd_car;
    logic            done;
    logic            result;

    modport master (
        output in_valid, data, cmd_ready,
        input  cmd_valid, cmd_op, cmd_car, done, result
    );

    modport slave (
        input  in_valid, data, cmd_ready,
        output cmd_valid, cmd_op, cmd_car, done, result
    );

endinterface

// File: rtl/train_siding_stack.sv
// LIFO model of the siding: DEPTH x W, push/pop update next cycle, top is combinational.
// No backpressure; the controller never pushes when full or pops when empty.
module train_siding_stack
    import train_pkg::*;
#(
    parameter int DEPTH = MAX_CARS_DEF,
    parameter int W     = ID_W_DEF,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_dat,
    output logic [W-1:0]    top,
    output logic [SP_W-1:0] sp
);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_m1;

    assign sp_m1 = sp - 1'b1;
    assign top   = (sp != '0) ? mem[sp_m1] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            sp <= '0;
        end else if (push) begin
            mem[sp] <= push_dat;
            sp      <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp_m1;
        end
    end

endmodule

// File: rtl/train_dispatch_ctrl.sv
// Loads N and a departure order, then emits the PUSH/POP stream that realises it on a stack siding.
// First cmd 2 cycles after last order beat, done 1 cycle after final step; stalls hold all state.
module train_dispatch_ctrl
    import train_pkg::*;
#(
    parameter int MAX_CARS = MAX_CARS_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    train_dispatch_ctrl_if.slave  bus
);

    localparam int              SP_W  = $clog2(MAX_CARS + 1);
    localparam logic [ID_W-1:0] MAX_N = ID_W'(MAX_CARS);

    state_t          state;
    logic [ID_W-1:0] n;
    logic [ID_W-1:0] k;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] skip;
    logic [ID_W:0]   next_in;
    logic [ID_W-1:0] order [MAX_CARS];

    logic            cmd_valid_q;
    logic            cmd_op_q;
    logic [ID_W-1:0] cmd_car_q;
    logic            done_q;
    logic            result_q;

    logic [ID_W-1:0] top;
    logic [SP_W-1:0] sp;
    logic [ID_W-1:0] want;
    logic            step;
    logic            all_gone;
    logic            can_pop;
    logic            can_push;
    logic            stk_push;
    logic            stk_pop;
    logic            stk_clr;

    always_comb begin
        want     = (idx < MAX_N) ? order[idx] : '0;
        step     = (state == RUN) && (!cmd_valid_q || bus.cmd_ready);
        all_gone = (idx == n);
        can_pop  = (sp != '0) && (top == want);
        can_push = (next_in <= {1'b0, n});
        stk_pop  = step && !all_gone && can_pop;
        stk_push = step && !all_gone && !can_pop && can_push;
        stk_clr  = (state == IDLE);
    end

    train_siding_stack #(
        .DEPTH (MAX_CARS),
        .W     (ID_W),
        .SP_W  (SP_W)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stk_clr),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dat (next_in[ID_W-1:0]),
        .top      (top),
        .sp       (sp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n           <= '0;
            k           <= '0;
            idx         <= '0;
            skip        <= '0;
            next_in     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_PUSH;
            cmd_car_q   <= '0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            for (int i = 0; i < MAX_CARS; i++) begin
                order[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    k       <= '0;
                    idx     <= '0;
                    next_in <= '0;
                    if (bus.in_valid) begin
                        // Order beats trailing a rejected header are swallowed here.
                        if (skip != '0) begin
                            skip <= skip - 1'b1;
                        end else begin
                            n <= bus.data;
                            if (bus.data == '0 || bus.data > MAX_N) begin
                                skip     <= bus.data;
                                done_q   <= 1'b1;
                                result_q <= 1'b0;
                                state    <= FIN;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        order[k] <= bus.data;
                        k        <= k + 1'b1;
                        if (k == n - 1'b1) begin
                            next_in <= (ID_W+1)'(1);
                            idx     <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (step) begin
                        if (all_gone) begin
                            cmd_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            result_q    <= 1'b1;
                            state       <= FIN;
                        end else if (can_pop) begin
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_POP;
                            cmd_car_q   <= top;
                            idx         <= idx + 1'b1;
                        end else if (can_push) begin
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_PUSH;
                            cmd_car_q   <= next_in[ID_W-1:0];
                            next_in     <= next_in + 1'b1;
                        end else begin
                            cmd_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            result_q    <= 1'b0;
                            state       <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q   <= 1'b0;
                    result_q <= 1'b0;
                    state    <= IDLE;
                    if (bus.in_valid && skip != '0) begin
                        skip <= skip - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_car   = cmd_car_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_train_dispatch_ctrl.sv
// Directed bench for train_dispatch_ctrl: drives headers/orders, records the command stream
// and compares against hand-derived PUSH/POP sequences (cmd encoded as op*16 + car).
module tb_train_dispatch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    train_dispatch_ctrl_if #(.ID_W(4)) bus ();

    train_dispatch_ctrl #(.MAX_CARS(10), .ID_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] ord [16];
    int exp_q [$];
    int got_q [$];
    int first_vld, last_hs, done_cyc, done_seen, res, stall_bad;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input int nv, input int nb);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data     = 4'(nv);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            bus.data = ord[i];
        end
    endtask

    // mode 0: cmd_ready always 1; mode 1: cmd_ready high every third cycle.
    task automatic collect(input int mode, input int max_hs, input int budget);
        logic stalled, p_op, rdy;
        logic [3:0] p_car;
        stalled = 1'b0; p_op = 1'b0; p_car = '0;
        got_q.delete();
        first_vld = 0; last_hs = 0; done_cyc = 0; done_seen = 0; res = -1; stall_bad = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.in_valid = 1'b0;
            if (stalled && (!bus.cmd_valid || bus.cmd_op !== p_op || bus.cmd_car !== p_car))
                stall_bad++;
            if (bus.done) begin
                done_seen = 1; done_cyc = cyc; res = int'(bus.result);
                break;
            end
            if (bus.cmd_valid && first_vld == 0) first_vld = cyc;
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            bus.cmd_ready = rdy;
            stalled = bus.cmd_valid && !rdy;
            p_op    = bus.cmd_op;
            p_car   = bus.cmd_car;
            if (bus.cmd_valid && rdy) begin
                got_q.push_back(int'(bus.cmd_op) * 16 + int'(bus.cmd_car));
                last_hs = cyc;
                if (got_q.size() == max_hs) break;
            end
        end
    endtask

    task automatic check_run(input string tag, input int exp_res);
        chk({tag, "_done"}, done_seen, 1);
        chk({tag, "_ncmd"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_done_gap"}, done_cyc - last_hs, 1);
        chk({tag, "_first_vld"}, first_vld, 2);
        chk({tag, "_stall"}, stall_bad, 0);
    endtask

    initial begin
        int bad;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.cmd_ready = 1'b0;
        #23;
        chk("reset_outs", {bus.cmd_valid, bus.cmd_op, bus.cmd_car, bus.done, bus.result}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // In-order departure: alternating push/pop.
        ord[0] = 1; ord[1] = 2; ord[2] = 3;
        send(3, 3);
        collect(0, 100, 100);
        exp_q = '{1, 17, 2, 18, 3, 19};
        check_run("inorder", 1);
        @(negedge clk);
        chk("inorder_done_pulse", bus.done, 0);

        // Infeasible: 3,1,2 stops after pop of 3.
        ord[0] = 3; ord[1] = 1; ord[2] = 2;
        send(3, 3);
        collect(0, 100, 100);
        exp_q = '{1, 2, 3, 19};
        check_run("infeasible", 0);

        // Full-depth reverse order.
        for (int i = 0; i < 10; i++) ord[i] = 4'(10 - i);
        send(10, 10);
        collect(0, 100, 100);
        exp_q.delete();
        for (int i = 1; i <= 10; i++) exp_q.push_back(i);
        for (int i = 10; i >= 1; i--) exp_q.push_back(16 + i);
        check_run("reverse10", 1);

        // Reverse 3 with stalling downstream.
        ord[0] = 3; ord[1] = 2; ord[2] = 1;
        send(3, 3);
        collect(1, 100, 200);
        exp_q = '{1, 2, 3, 19, 18, 17};
        check_run("stall", 1);

        // N = 0: immediate failure, no commands.
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.data     = 4'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("n0_done", {bus.done, bus.result, bus.cmd_valid}, 3'b100);
        @(negedge clk);
        chk("n0_after", {bus.done, bus.cmd_valid}, 0);

        // N = 12: immediate failure; the 12 trailing beats must be ignored.
        bus.in_valid = 1'b1;
        bus.data     = 4'd12;
        @(negedge clk);
        chk("n12_done", {bus.done, bus.result, bus.cmd_valid}, 3'b100);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            bus.data = 4'(i + 1);
            @(negedge clk);
            if (bus.done || bus.cmd_valid) bad++;
        end
        bus.in_valid = 1'b0;
        chk("n12_quiet", bad, 0);
        ord[0] = 1;
        send(1, 1);
        collect(0, 100, 100);
        exp_q = '{1, 17};
        check_run("after_n12", 1);

        // Reset mid-run after the third command.
        ord[0] = 2; ord[1] = 1; ord[2] = 4; ord[3] = 3;
        send(4, 4);
        collect(0, 3, 100);
        exp_q = '{1, 2, 18};
        chk("prerst_ncmd", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("prerst_cmd%0d", i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        @(posedge clk);
        #2;
        chk("prerst_pending", {bus.cmd_valid, bus.cmd_op, bus.cmd_car}, {1'b1, 1'b1, 4'd1});
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {bus.cmd_valid, bus.cmd_op, bus.cmd_car, bus.done, bus.result}, 0);
        bus.cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_hold", {bus.cmd_valid, bus.done}, 0);
        rst_n = 1'b1;
        ord[0] = 1;
        send(1, 1);
        collect(0, 100, 100);
        exp_q = '{1, 17};
        check_run("post_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
